sata_oob_controller: RTL and testbench



---
 rtl/sata_oob_pkg.sv | 34 +++
 rtl/sata_timeout_timer.sv | 36 +++
 rtl/sata_oob_controller.sv | 182 ++++++++++++++++++
 tb/tb_sata_oob_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_oob_pkg.sv
// Shared types and helpers for the SATA host OOB / link-initialization sequencer.
package sata_oob_pkg;

  typedef enum logic [3:0] {
    RESET_ST      = 4'd0,
    SEND_COMRESET = 4'd1,
    WAIT_COMINIT  = 4'd2,
    SEND_COMWAKE  = 4'd3,
    WAIT_COMWAKE  = 4'd4,
    WAIT_OOBFIN   = 4'd5,
    WAIT_ALIGN    = 4'd6,
    SEND_ALIGN    = 4'd7,
    LINKUP        = 4'd8
  } oob_state_t;

  typedef enum logic {
    COMRESET = 1'b0,
    COMWAKE  = 1'b1
  } oob_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D10_2 = 2'd1,
    ALIGN = 2'd2,
    DATA  = 2'd3
  } tx_sel_t;

  // 64-bit so that MHz-range clocks times millisecond timeouts cannot overflow.
  function automatic longint unsigned us2cycles(input longint unsigned freq_khz,
                                                input longint unsigned us);
    return (freq_khz * us) / 64'd1000;
  endfunction

endpackage

// File: rtl/sata_timeout_timer.sv
// Saturating up-counter with a runtime-selectable limit; LIMIT sizes the counter.
module sata_timeout_timer #(
  parameter longint unsigned LIMIT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  logic [$clog2(LIMIT+1)-1:0]     limit_i,
  output logic                           expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/sata_oob_controller.sv
// Host-side SATA OOB + ALIGN sequencer; define SATA_OOB_CONTROLLER_STATUS_EN
// to expose state_o and the saturating retry_cnt.
//
// state         | meaning
// RESET_ST      | one idle cycle after reset
// SEND_COMRESET | request COMRESET burst, wait for oob_ack
// WAIT_COMINIT  | wait for device COMINIT (retry timeout)
// SEND_COMWAKE  | request COMWAKE burst, wait for oob_ack
// WAIT_COMWAKE  | wait for device COMWAKE (retry timeout)
// WAIT_OOBFIN   | send D10.2, wait for end of OOB (align timeout)
// WAIT_ALIGN    | send D10.2, wait for received ALIGN (align timeout)
// SEND_ALIGN    | send ALIGN, wait for run of non-ALIGN primitives
// LINKUP        | link established, link layer owns the transmitter
module sata_oob_controller
  import sata_oob_pkg::*;
#(
  parameter int unsigned CLKFREQ      = 150_000,
  parameter int unsigned RETRY_US     = 10_000,
  parameter int unsigned ALIGN_US     = 880,
  parameter int unsigned NONALIGN_CNT = 3
) (
  input  logic       reset,
  input  logic       clk,
  input  logic       cominit,
  input  logic       comwake,
  input  logic       oobfinish,
  output logic       oob_req,
  output logic       oob_type,
  input  logic       oob_ack,
  input  logic       rx_align,
  input  logic       rx_prim,
  output logic [1:0] tx_sel,
  output logic       linkup
`ifdef SATA_OOB_CONTROLLER_STATUS_EN
  ,
  output logic [3:0] state_o,
  output logic [7:0] retry_cnt
`endif
);

  localparam longint unsigned T_RETRY = us2cycles(64'(CLKFREQ), 64'(RETRY_US));
  localparam longint unsigned T_ALIGN = us2cycles(64'(CLKFREQ), 64'(ALIGN_US));
  localparam longint unsigned T_MAX   = (T_RETRY > T_ALIGN) ? T_RETRY : T_ALIGN;
  localparam int TW = $clog2(T_MAX + 1);
  localparam int NW = $clog2(NONALIGN_CNT + 1);

  oob_state_t state_q, state_d;

  logic          tmr_en, tmr_clr, tmr_expired;
  logic [TW-1:0] tmr_limit;

  logic [NW-1:0] na_q, na_d;
  logic          na_hit, na_done;

  logic      oob_req_q, oob_req_d;
  oob_type_t oob_type_q, oob_type_d;
  tx_sel_t   tx_sel_q, tx_sel_d;
  logic      linkup_q, linkup_d;

  always_comb begin
    tmr_en    = 1'b0;
    tmr_limit = TW'(T_RETRY);
    case (state_q)
      WAIT_COMINIT, WAIT_COMWAKE: tmr_en = 1'b1;
      WAIT_OOBFIN, WAIT_ALIGN, SEND_ALIGN: begin
        tmr_en    = 1'b1;
        tmr_limit = TW'(T_ALIGN);
      end
      default: ;
    endcase
  end

  assign tmr_clr = (state_d != state_q);

  sata_timeout_timer #(
    .LIMIT(T_MAX)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tmr_clr),
    .enable_i (tmr_en),
    .limit_i  (tmr_limit),
    .expired_o(tmr_expired)
  );

  assign na_hit  = rx_prim && !rx_align;
  assign na_done = na_hit && (na_q == NW'(NONALIGN_CNT - 1));

  always_comb begin
    na_d = '0;
    if ((state_q == SEND_ALIGN) && !rx_align) begin
      na_d = na_hit ? (na_q + NW'(1)) : na_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_ST:      state_d = SEND_COMRESET;
      SEND_COMRESET: if (oob_ack) state_d = WAIT_COMINIT;
      WAIT_COMINIT: begin
        if (cominit)          state_d = SEND_COMWAKE;
        else if (tmr_expired) state_d = SEND_COMRESET;
      end
      SEND_COMWAKE:  if (oob_ack) state_d = WAIT_COMWAKE;
      WAIT_COMWAKE: begin
        if (comwake)          state_d = WAIT_OOBFIN;
        else if (tmr_expired) state_d = SEND_COMRESET;
      end
      WAIT_OOBFIN: begin
        if (oobfinish)        state_d = WAIT_ALIGN;
        else if (tmr_expired) state_d = SEND_COMRESET;
      end
      WAIT_ALIGN: begin
        if (rx_align)         state_d = SEND_ALIGN;
        else if (tmr_expired) state_d = SEND_COMRESET;
      end
      SEND_ALIGN: begin
        if (na_done)          state_d = LINKUP;
        else if (tmr_expired) state_d = SEND_COMRESET;
      end
      LINKUP:        state_d = LINKUP;
      default:       state_d = RESET_ST;
    endcase
    // An unexpected COMINIT means the device restarted; start over.
    if (cominit && (state_q != WAIT_COMINIT) && (state_q != SEND_COMWAKE)) begin
      state_d = SEND_COMRESET;
    end

    oob_req_d  = (state_d == SEND_COMRESET) || (state_d == SEND_COMWAKE);
    oob_type_d = (state_d == SEND_COMWAKE) ? COMWAKE : COMRESET;
    linkup_d   = (state_d == LINKUP);
    case (state_d)
      WAIT_OOBFIN, WAIT_ALIGN: tx_sel_d = D10_2;
      SEND_ALIGN:              tx_sel_d = ALIGN;
      LINKUP:                  tx_sel_d = DATA;
      default:                 tx_sel_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_ST;
      na_q       <= '0;
      oob_req_q  <= 1'b0;
      oob_type_q <= COMRESET;
      tx_sel_q   <= IDLE;
      linkup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      na_q       <= na_d;
      oob_req_q  <= oob_req_d;
      oob_type_q <= oob_type_d;
      tx_sel_q   <= tx_sel_d;
      linkup_q   <= linkup_d;
    end
  end

  assign oob_req  = oob_req_q;
  assign oob_type = oob_type_q;
  assign tx_sel   = tx_sel_q;
  assign linkup   = linkup_q;

`ifdef SATA_OOB_CONTROLLER_STATUS_EN
  logic [7:0] retry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
    end else if ((state_d == LINKUP) && (state_q != LINKUP)) begin
      retry_q <= '0;
    end else if ((state_d == SEND_COMRESET) && (state_q != SEND_COMRESET) &&
                 (state_q != RESET_ST) && (retry_q != 8'hFF)) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_cnt = retry_q;
  assign state_o   = state_q;
`endif

endmodule

// File: tb/tb_sata_oob_controller.sv
// Directed-sequence bench with randomized timing for sata_oob_controller; expected
// outputs follow the link-bring-up rules phase by phase.
module tb_sata_oob_controller;

  localparam int CLKFREQ  = 1000;
  localparam int RETRY_US = 100;
  localparam int ALIGN_US = 50;
  localparam int NA       = 3;
  localparam int T_RETRY  = CLKFREQ * RETRY_US / 1000;
  localparam int T_ALIGN  = CLKFREQ * ALIGN_US / 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cominit = 1'b0, comwake = 1'b0, oobfinish = 1'b0;
  logic       oob_ack = 1'b0, rx_align = 1'b0, rx_prim = 1'b0;
  logic       oob_req, oob_type, linkup;
  logic [1:0] tx_sel;
`ifdef SATA_OOB_CONTROLLER_STATUS_EN
  logic [3:0] state_o;
  logic [7:0] retry_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic       e_req, e_type, e_lu;
  logic [1:0] e_tx;
  int         e_retry;

  sata_oob_controller #(
    .CLKFREQ     (CLKFREQ),
    .RETRY_US    (RETRY_US),
    .ALIGN_US    (ALIGN_US),
    .NONALIGN_CNT(NA)
  ) dut (
    .reset    (reset),
    .clk      (clk),
    .cominit  (cominit),
    .comwake  (comwake),
    .oobfinish(oobfinish),
    .oob_req  (oob_req),
    .oob_type (oob_type),
    .oob_ack  (oob_ack),
    .rx_align (rx_align),
    .rx_prim  (rx_prim),
    .tx_sel   (tx_sel),
    .linkup   (linkup)
`ifdef SATA_OOB_CONTROLLER_STATUS_EN
    ,
    .state_o  (state_o),
    .retry_cnt(retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of sequence, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag);
    check({tag, ".oob_req"},  {31'd0, oob_req},  {31'd0, e_req});
    check({tag, ".oob_type"}, {31'd0, oob_type}, {31'd0, e_type});
    check({tag, ".tx_sel"},   {30'd0, tx_sel},   {30'd0, e_tx});
    check({tag, ".linkup"},   {31'd0, linkup},   {31'd0, e_lu});
`ifdef SATA_OOB_CONTROLLER_STATUS_EN
    check({tag, ".retry_cnt"}, {24'd0, retry_cnt}, 32'(e_retry));
`endif
  endtask

  // Expected output sets for each phase of the bring-up.
  task automatic exp_comreset(input bit counted);
    e_req = 1'b1; e_type = 1'b0; e_tx = 2'd0; e_lu = 1'b0;
    if (counted && e_retry < 255) e_retry++;
  endtask
  task automatic exp_idle();    e_req = 1'b0; e_type = 1'b0; e_tx = 2'd0; e_lu = 1'b0; endtask
  task automatic exp_comwake(); e_req = 1'b1; e_type = 1'b1; e_tx = 2'd0; e_lu = 1'b0; endtask
  task automatic exp_d102();    e_req = 1'b0; e_type = 1'b0; e_tx = 2'd1; e_lu = 1'b0; endtask
  task automatic exp_align();   e_req = 1'b0; e_type = 1'b0; e_tx = 2'd2; e_lu = 1'b0; endtask
  task automatic exp_linkup();  e_req = 1'b0; e_type = 1'b0; e_tx = 2'd3; e_lu = 1'b1; e_retry = 0; endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n cycles in which the DUT must not move; optional harmless noise.
  task automatic hold(input int n, input bit ack_noise, input bit ci_noise, input string tag);
    for (int i = 0; i < n; i++) begin
      oob_ack = ack_noise && ($urandom_range(0, 3) == 0);
      cominit = ci_noise && ($urandom_range(0, 3) == 0);
      tick();
      oob_ack = 1'b0;
      cominit = 1'b0;
      expect_out(tag);
    end
  endtask

  task automatic ack_comreset(input int d);
    hold(d, 1'b0, 1'b0, "comreset_hold");
    oob_ack = 1'b1; tick(); oob_ack = 1'b0;
    exp_idle(); expect_out("comreset_ack");
  endtask

  task automatic cominit_after(input int d);
    hold(d, 1'b1, 1'b0, "wait_cominit");
    cominit = 1'b1; tick(); cominit = 1'b0;
    exp_comwake(); expect_out("cominit");
  endtask

  task automatic ack_comwake(input int d);
    hold(d, 1'b0, 1'b1, "comwake_hold");
    oob_ack = 1'b1; tick(); oob_ack = 1'b0;
    exp_idle(); expect_out("comwake_ack");
  endtask

  task automatic comwake_after(input int d);
    hold(d, 1'b1, 1'b0, "wait_comwake");
    comwake = 1'b1; tick(); comwake = 1'b0;
    exp_d102(); expect_out("comwake");
  endtask

  task automatic oobfin_after(input int d);
    hold(d, 1'b1, 1'b0, "wait_oobfin");
    oobfinish = 1'b1; tick(); oobfinish = 1'b0;
    expect_out("oobfinish");
  endtask

  task automatic align_after(input int d);
    hold(d, 1'b1, 1'b0, "wait_align");
    rx_align = 1'b1; rx_prim = 1'b1; tick(); rx_align = 1'b0; rx_prim = 1'b0;
    exp_align(); expect_out("rx_align");
  endtask

  // A timed phase lasts limit+1 cycles (timer values 0..limit), then COMRESET.
  task automatic timeout_phase(input int limit, input string tag);
    hold(limit, 1'b1, 1'b0, tag);
    tick();
    exp_comreset(1'b1); expect_out({tag, "_timeout"});
  endtask

  // Words: 0 = no primitive, 1 = ALIGN, 2 = other primitive.
  task automatic send_words(input int w[$]);
    int run = 0;
    foreach (w[i]) begin
      rx_align = (w[i] == 1);
      rx_prim  = (w[i] != 0);
      tick();
      rx_align = 1'b0; rx_prim = 1'b0;
      if (w[i] == 1) run = 0;
      else if (w[i] == 2) run++;
      if (run == NA) begin
        exp_linkup(); expect_out("linkup");
        return;
      end
      expect_out("send_align");
    end
  endtask

  task automatic unsolicited_cominit(input string tag);
    cominit = 1'b1; tick(); cominit = 1'b0;
    exp_comreset(1'b1); expect_out(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    exp_idle(); e_retry = 0;
    expect_out({tag, "_async"});
    tick(); expect_out({tag, "_held"});
    reset = 1'b0;
    expect_out({tag, "_release"});
    tick();
    exp_comreset(1'b0); expect_out({tag, "_restart"});
  endtask

  task automatic random_bring_up();
    int wq[$];
    int len;
    ack_comreset($urandom_range(0, 8));
    cominit_after($urandom_range(0, T_RETRY));
    ack_comwake($urandom_range(0, 8));
    comwake_after($urandom_range(0, T_RETRY - 1));
    oobfin_after($urandom_range(0, T_ALIGN - 1));
    align_after($urandom_range(0, T_ALIGN - 1));
    len = $urandom_range(0, 12);
    for (int i = 0; i < len; i++) wq.push_back($urandom_range(0, 2));
    for (int i = 0; i < NA; i++) wq.push_back(2);
    send_words(wq);
  endtask

  initial begin
    int wq[$];
    e_retry = 0;
    #1 reset = 1'b1;
    #1;
    exp_idle(); expect_out("reset");
    tick(); tick();
    reset = 1'b0;
    expect_out("reset_release");
    tick();
    exp_comreset(1'b0); expect_out("first_comreset");

    // Nominal bring-up; tx_sel walks 0,1,2,3.
    ack_comreset(4);
    cominit_after(15);
    ack_comwake(9);
    comwake_after(4);
    oobfin_after(3);
    align_after(2);
    wq = {2, 2, 2};
    send_words(wq);
    unsolicited_cominit("cominit_in_linkup");

    // COMINIT at the exact retry boundary still wins; broken non-ALIGN run.
    ack_comreset(2);
    cominit_after(T_RETRY);
    ack_comwake(1);
    comwake_after(T_RETRY - 1);
    oobfin_after(0);
    align_after(T_ALIGN - 1);
    wq = {2, 0, 2, 1, 2, 0, 2, 2};
    send_words(wq);
    unsolicited_cominit("cominit_in_linkup2");

    // Retry timeouts in each timed phase.
    ack_comreset(3);
    timeout_phase(T_RETRY, "wait_cominit");
    ack_comreset(0);
    cominit_after(7);
    ack_comwake(2);
    timeout_phase(T_RETRY, "wait_comwake");
    ack_comreset(1);
    cominit_after(3);
    ack_comwake(0);
    comwake_after(5);
    timeout_phase(T_ALIGN, "wait_oobfin");
    ack_comreset(1);
    cominit_after(3);
    ack_comwake(0);
    comwake_after(5);
    oobfin_after(2);
    timeout_phase(T_ALIGN, "wait_align");
    ack_comreset(1);
    cominit_after(3);
    ack_comwake(0);
    comwake_after(5);
    oobfin_after(2);
    align_after(6);
    timeout_phase(T_ALIGN, "send_align");

    // COMINIT while sending D10.2 restarts the sequence.
    ack_comreset(2);
    cominit_after(4);
    ack_comwake(3);
    comwake_after(6);
    unsolicited_cominit("cominit_in_oobfin");

    for (int it = 0; it < 6; it++) begin
      random_bring_up();
      unsolicited_cominit("cominit_random");
    end

    // Asynchronous reset while COMWAKE is requested, then while linked up.
    ack_comreset(2);
    cominit_after(10);
    async_reset("reset_in_comwake");
    random_bring_up();
    async_reset("reset_in_linkup");
    ack_comreset(5);
    expect_out("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
